// File: rtl/game_pkg.sv
// Shared types and constants for the binary-match game sequencer.
package game_pkg;

  localparam int SCORE_W   = 4;
  localparam int SCORE_MAX = 15;
  localparam int TIME_W    = 6;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PLAY     = 2'd1,
    COOLDOWN = 2'd2,
    OVER     = 2'd3
  } state_t;

  function automatic logic [SCORE_W-1:0] max_score(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/round_timer.sv
// Game-second tick divider and seconds-left down-counter.
module round_timer
  import game_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              run,
  input  logic [TIME_W-1:0] load_val,
  output logic [TIME_W-1:0] time_remaining,
  output logic              expire
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick_wrap;

  // expire marks the cycle whose closing edge takes the count from 1 to 0,
  // so the controller can leave the round on that same edge.
  assign tick_wrap = run && (tick_cnt == TICK_LAST);
  assign expire    = tick_wrap && (time_remaining == TIME_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt       <= '0;
      time_remaining <= '0;
    end else if (load) begin
      tick_cnt       <= '0;
      time_remaining <= load_val;
    end else if (run) begin
      if (tick_wrap) begin
        tick_cnt <= '0;
        if (time_remaining != '0) begin
          time_remaining <= time_remaining - 1'b1;
        end
      end else begin
        tick_cnt <= tick_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_controller.sv
// Per-game sequencer: start/play/cooldown/over control, match crediting,
// score, persistent high score and new-target requests.
module game_controller
  import game_pkg::*;
#(
  parameter int TICK_DIV     = 100_000_000,
  parameter int GAME_SECONDS = 30,
  parameter int MATCH_HOLD   = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [7:0]         sw,
  input  logic [7:0]         target,
  output logic               next_num,
  output logic               playing,
  output logic               game_end,
  output logic [TIME_W-1:0]  time_remaining,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score
);

  localparam int HOLD_W = (MATCH_HOLD > 1) ? $clog2(MATCH_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(MATCH_HOLD - 1);
  localparam logic [TIME_W-1:0]  START_TIME = TIME_W'(GAME_SECONDS);
  localparam logic [SCORE_W-1:0] SCORE_LAST = SCORE_W'(SCORE_MAX - 1);
  localparam logic [SCORE_W-1:0] SCORE_TOP  = SCORE_W'(SCORE_MAX);

  state_t            state;
  logic              start_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic              start_evt;
  logic              match;
  logic              timer_load;
  logic              timer_run;
  logic              expire;
  logic              credit;

  assign start_evt  = start && !start_q;
  assign match      = (sw == target);
  assign timer_load = start_evt && ((state == IDLE) || (state == OVER));
  assign timer_run  = (state == PLAY) || (state == COOLDOWN);

  // A timeout on the same edge as a completed hold takes priority.
  assign credit = (state == PLAY) && match && (hold_cnt == HOLD_LAST) && !expire;

  round_timer #(
    .TICK_DIV(TICK_DIV)
  ) u_timer (
    .clk           (clk),
    .rst_n         (rst_n),
    .load          (timer_load),
    .run           (timer_run),
    .load_val      (START_TIME),
    .time_remaining(time_remaining),
    .expire        (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      hold_cnt   <= '0;
      score      <= '0;
      high_score <= '0;
      next_num   <= 1'b0;
      playing    <= 1'b0;
      game_end   <= 1'b0;
    end else begin
      start_q  <= start;
      next_num <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (timer_load) begin
            state    <= PLAY;
            score    <= '0;
            hold_cnt <= '0;
            next_num <= 1'b1;
            playing  <= 1'b1;
            game_end <= 1'b0;
          end
        end
        PLAY: begin
          if (expire) begin
            state      <= OVER;
            hold_cnt   <= '0;
            playing    <= 1'b0;
            game_end   <= 1'b1;
            high_score <= max_score(high_score, score);
          end else if (credit) begin
            hold_cnt <= '0;
            score    <= score + 1'b1;
            // The fifteenth point ends the game without asking for a new target.
            if (score == SCORE_LAST) begin
              state      <= OVER;
              playing    <= 1'b0;
              game_end   <= 1'b1;
              high_score <= max_score(high_score, SCORE_TOP);
            end else begin
              state    <= COOLDOWN;
              next_num <= 1'b1;
            end
          end else if (match) begin
            hold_cnt <= hold_cnt + 1'b1;
          end else begin
            hold_cnt <= '0;
          end
        end
        COOLDOWN: begin
          if (expire) begin
            state      <= OVER;
            hold_cnt   <= '0;
            playing    <= 1'b0;
            game_end   <= 1'b1;
            high_score <= max_score(high_score, score);
          end else if (!match) begin
            state    <= PLAY;
            hold_cnt <= '0;
          end
        end
        default: begin
          state   <= IDLE;
          playing <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: vector table through a scoreboard
// queue, plus hand sequences for asynchronous reset and the score cap.
module tb_game_controller;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] sw;
  logic [7:0] target;

  logic       next1, play1, end1;
  logic [5:0] time1;
  logic [3:0] score1, high1;

  logic       next2, play2, end2;
  logic [5:0] time2;
  logic [3:0] score2, high2;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  typedef struct {
    logic       start;
    logic [7:0] sw;
    logic [7:0] target;
    logic       p;
    logic       n;
    logic       e;
    logic [5:0] t;
    logic [3:0] s;
    logic [3:0] h;
  } vec_t;

  typedef struct {
    int         idx;
    logic       p;
    logic       n;
    logic       e;
    logic [5:0] t;
    logic [3:0] s;
    logic [3:0] h;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  game_controller #(.TICK_DIV(4), .GAME_SECONDS(3), .MATCH_HOLD(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sw(sw), .target(target),
    .next_num(next1), .playing(play1), .game_end(end1),
    .time_remaining(time1), .score(score1), .high_score(high1)
  );

  game_controller #(.TICK_DIV(4), .GAME_SECONDS(63), .MATCH_HOLD(2)) dut_cap (
    .clk(clk), .rst_n(rst_n), .start(start), .sw(sw), .target(target),
    .next_num(next2), .playing(play2), .game_end(end2),
    .time_remaining(time2), .score(score2), .high_score(high2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void addVec(input logic st, input logic [7:0] s, input logic [7:0] t,
                                 input logic p, input logic n, input logic e,
                                 input logic [5:0] tr, input logic [3:0] sc, input logic [3:0] hs);
    vec_t v;
    v.start = st; v.sw = s; v.target = t;
    v.p = p; v.n = n; v.e = e; v.t = tr; v.s = sc; v.h = hs;
    vecs.push_back(v);
  endfunction

  task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    exp_t e;
    start  = v.start;
    sw     = v.sw;
    target = v.target;
    e.idx = idx; e.p = v.p; e.n = v.n; e.e = v.e; e.t = v.t; e.s = v.s; e.h = v.h;
    sbq.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("[TB] FAIL scoreboard: no expected entry queued");
      return;
    end
    e = sbq.pop_front();
    if ({play1, next1, end1, time1, score1, high1} !== {e.p, e.n, e.e, e.t, e.s, e.h}) begin
      errors++;
      $display("[TB] FAIL vec%0d: got playing=%b next=%b end=%b time=%0d score=%0d high=%0d, expected playing=%b next=%b end=%b time=%0d score=%0d high=%0d",
               e.idx, play1, next1, end1, time1, score1, high1, e.p, e.n, e.e, e.t, e.s, e.h);
    end
  endtask

  task automatic stepCap(input logic st, input logic [7:0] s);
    start = st;
    sw    = s;
    @(posedge clk);
    @(negedge clk);
    if (next2) pulses++;
  endtask

  initial begin
    logic [5:0] tr;
    rst_n  = 1'b1;
    start  = 1'b0;
    sw     = 8'h00;
    target = 8'h00;
    #2 rst_n = 1'b0;
    #2;
    compareVal("reset_dut", {play1, next1, end1, time1, score1, high1}, 32'd0);
    compareVal("reset_dut_cap", {play2, next2, end2, time2, score2, high2}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Game 1: no match, runs out of time.
    addVec(1, 8'h00, 8'h3C, 1, 1, 0, 3, 0, 0);
    for (int i = 1; i <= 13; i++) begin
      tr = (i < 4) ? 6'd3 : (i < 8) ? 6'd2 : (i < 12) ? 6'd1 : 6'd0;
      if (i < 12) addVec(0, 8'h00, 8'h3C, 1, 0, 0, tr, 0, 0);
      else        addVec(0, 8'h00, 8'h3C, 0, 0, 1, 0, 0, 0);
    end

    // Game 2: two credits, cooldown, short-hold glitches, match on final tick.
    addVec(1, 8'h00, 8'hA5, 1, 1, 0, 3, 0, 0);
    addVec(0, 8'hA5, 8'hA5, 1, 0, 0, 3, 0, 0);
    addVec(0, 8'hA5, 8'hA5, 1, 1, 0, 3, 1, 0);
    addVec(0, 8'hA5, 8'hA5, 1, 0, 0, 3, 1, 0);
    addVec(0, 8'hA5, 8'hA5, 1, 0, 0, 2, 1, 0);
    addVec(0, 8'h00, 8'hA5, 1, 0, 0, 2, 1, 0);
    addVec(0, 8'h5A, 8'h5A, 1, 0, 0, 2, 1, 0);
    addVec(0, 8'h5A, 8'h5A, 1, 1, 0, 2, 2, 0);
    addVec(0, 8'h00, 8'h5A, 1, 0, 0, 1, 2, 0);
    addVec(0, 8'h5A, 8'h5A, 1, 0, 0, 1, 2, 0);
    addVec(0, 8'h00, 8'h5A, 1, 0, 0, 1, 2, 0);
    addVec(0, 8'h5A, 8'h5A, 1, 0, 0, 1, 2, 0);
    addVec(0, 8'h5A, 8'h5A, 0, 0, 1, 0, 2, 2);
    addVec(0, 8'h00, 8'h5A, 0, 0, 1, 0, 2, 2);

    // Game 3: one credit, start pulse mid-game ignored, high score kept at 2.
    addVec(1, 8'h00, 8'h11, 1, 1, 0, 3, 0, 2);
    addVec(0, 8'h11, 8'h11, 1, 0, 0, 3, 0, 2);
    addVec(0, 8'h11, 8'h11, 1, 1, 0, 3, 1, 2);
    addVec(0, 8'h11, 8'h11, 1, 0, 0, 3, 1, 2);
    addVec(0, 8'h11, 8'h11, 1, 0, 0, 2, 1, 2);
    addVec(0, 8'h11, 8'h11, 1, 0, 0, 2, 1, 2);
    addVec(1, 8'h11, 8'h11, 1, 0, 0, 2, 1, 2);
    addVec(0, 8'h11, 8'h11, 1, 0, 0, 2, 1, 2);
    for (int i = 8; i <= 11; i++) addVec(0, 8'h11, 8'h11, 1, 0, 0, 1, 1, 2);
    addVec(0, 8'h11, 8'h11, 0, 0, 1, 0, 1, 2);

    // Game 4 start, used for the mid-game reset below.
    addVec(1, 8'h00, 8'h22, 1, 1, 0, 3, 0, 2);
    addVec(0, 8'h00, 8'h22, 1, 0, 0, 3, 0, 2);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
      @(posedge clk);
      @(negedge clk);
      checkOutput();
    end

    // Asynchronous reset in the middle of a game.
    #2 rst_n = 1'b0;
    #1;
    compareVal("async_reset", {play1, next1, end1, time1, score1, high1}, 32'd0);
    compareVal("async_reset_cap", {play2, next2, end2, time2, score2, high2}, 32'd0);
    start = 1'b0;
    sw    = 8'h00;
    target = 8'h77;
    @(negedge clk);
    rst_n = 1'b1;

    // Score cap on the long-game instance.
    pulses = 0;
    stepCap(1, 8'h00);
    compareVal("cap_start", {play2, next2, end2, time2}, {1'b1, 1'b1, 1'b0, 6'd63});
    stepCap(0, 8'h00);
    for (int k = 1; k <= 15; k++) begin
      stepCap(0, 8'h77);
      stepCap(0, 8'h77);
      compareVal($sformatf("cap_score%0d", k), {28'd0, score2}, k);
      if (k == 15) begin
        compareVal("cap_over", {play2, next2, end2, time2, high2}, {1'b0, 1'b0, 1'b1, 6'd52, 4'd15});
      end else begin
        compareVal($sformatf("cap_credit%0d", k), {play2, next2, end2}, 3'b110);
      end
      stepCap(0, 8'h00);
    end
    repeat (8) stepCap(0, 8'h77);
    compareVal("cap_frozen", {play2, end2, time2, score2, high2}, {1'b0, 1'b1, 6'd52, 4'd15, 4'd15});
    compareVal("cap_next_pulses", pulses, 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_controller.md
# game_controller

Top-level sequencer for the binary-match game. It runs the per-game state machine (idle → playing → over), owns the 30-second countdown and the score, and requests a new random target after each credited match. It sits between the switch/button inputs and the random-number, display and comparator datapath, and replaces their ad-hoc reset-driven sequencing with explicit start/over control and a persistent high score.

## Interface
- `TICK_DIV`, default 100_000_000: `clk` cycles per game second.
- `GAME_SECONDS`, default 30: countdown start value; must be ≤ 63.
- `MATCH_HOLD`, default 1_000_000: consecutive cycles `sw == target` must hold before a match is credited; must be ≥ 1.
- `clk`, in, 1: the block's only clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: debounced start button level, synchronous to `clk`.
- `sw`, in, 8: player's switch value.
- `target`, in, 8: current random number from the generator.
- `next_num`, out, 1: one-cycle request to the generator for a new target.
- `playing`, out, 1: high in PLAY and COOLDOWN.
- `game_end`, out, 1: high in OVER.
- `time_remaining`, out, 6: seconds left.
- `score`, out, 4: current-game score.
- `high_score`, out, 4: best score since reset.

## Operation
- Reset values of all outputs are 0. The state is IDLE. Internal counters and `start_q` are also 0.
- Start event: `start && !start_q`, where `start_q` is `start` registered on the previous cycle. This is the only way to begin a game.
- States:
  - IDLE: On a start event, go to PLAY, load `time_remaining` with GAME_SECONDS, clear `score`, the tick counter and the hold counter, and pulse `next_num`.
  - PLAY: The tick counter runs 0..TICK_DIV-1. On wrap, `time_remaining` decrements. The hold counter increments while `sw == target` and clears otherwise. When the hold counter reaches MATCH_HOLD, `score` increments, `next_num` pulses, the hold counter clears, and the state goes to COOLDOWN.
  - COOLDOWN: The timer keeps running. Go back to PLAY on the first cycle where `sw != target`. This guarantees each setting of the switches earns at most one point.
  - OVER: `game_end` is 1. `score` and `time_remaining` hold their values. A start event begins a new game exactly as from IDLE.
- Timeout: On a tick wrap with `time_remaining == 1`, `time_remaining` becomes 0 and the state goes to OVER from either PLAY or COOLDOWN.
- Score cap: A credit that makes `score == 15` goes to OVER immediately. `time_remaining` freezes at its current value and `next_num` is not pulsed.
- High score: On the cycle of entry to OVER, `high_score` is set to max(`high_score`, final `score`). Only `rst_n` clears it.
- Simultaneous timeout and match credit in the same cycle: the timeout wins. No point is credited and `next_num` is not pulsed.
- Start events in PLAY and COOLDOWN are ignored.
- `rst_n` asserted mid-game forces IDLE immediately and clears everything, including `high_score`.

## Timing
- All outputs are registered.
- A start event seen in cycle N gives `playing = 1`, `next_num = 1` and `time_remaining = GAME_SECONDS` in cycle N+1.
- With `sw == target` first true in cycle N and held, `score` and `next_num` update in cycle N+MATCH_HOLD.
- `next_num` is exactly one cycle wide.
- A new `target` may arrive any number of cycles after `next_num`. COOLDOWN tolerates this delay.
- The first decrement comes TICK_DIV cycles after entering PLAY. A game therefore lasts GAME_SECONDS×TICK_DIV cycles.

## Structure
- Package `game_pkg` holds:
  - the state enum (IDLE, PLAY, COOLDOWN, OVER);
  - `SCORE_W = 4`, `SCORE_MAX = 15`;
  - `TIME_W = 6`.
- Sub-module `round_timer` contains the tick counter and the seconds down-counter. Its interface is: `load`, `run` and `load_val` in; `time_remaining` and `expire` out. `expire` is a one-cycle pulse on the 1→0 transition.
- The FSM, hold counter, score and high-score logic stay in `game_controller`.

## Test plan
Parameters for all scenarios: TICK_DIV=4, GAME_SECONDS=3, MATCH_HOLD=2.
- Reset then start pulse → the next cycle has `playing = 1`, `next_num = 1` for one cycle, `time_remaining = 3`, `score = 0`. With no match, `time_remaining` reads 2, 1 and 0 at +4, +8 and +12 cycles, and `game_end = 1` from +12.
- `sw = target = 8'hA5` for 2 cycles → `score = 1` and a `next_num` pulse. Holding `sw` while `target` stays `8'hA5` earns no second point. Changing `sw` and then matching the new target for 2 cycles → `score = 2`.
- `sw == target` for 1 cycle, then a mismatch, then a match for 1 cycle → `score` stays 0.
- Match completes on the same cycle as the final tick → `score` unchanged, no `next_num`, `game_end = 1`.
- Game 1 ends with score 2 and game 2 ends with score 1 → `high_score = 2` after both. Crediting 15 points with a large GAME_SECONDS → OVER on the 15th credit, `score = 15`, `high_score = 15`.
- `rst_n` low mid-PLAY → all outputs 0 asynchronously. A start pulse during PLAY → no effect on `time_remaining` or `score`.
